muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
Multi-cycle multiply (and optional divide) sequencer in the EX stage. It accepts an M-extension op decoded by the control unit and runs a radix-2 iterative datapath. While running it holds stall_EX high, which stalls the control unit and fetch. It presents the result for one cycle so the stalled instruction can write back.

Parameters:
WIDTH, 32, operand and result width in bits; also the iteration count
CNT_W, $clog2(WIDTH), width of the iteration counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  EX-stage instruction is an M-op; sampled only in IDLE
aluop  input  4  op code from control unit: 0101 mul, 0110 mulh, 0111 mulhu (1110 divu, 1111 remu with MULDIV_DIV_EN)
op_a  input  WIDTH  rs1 operand
op_b  input  WIDTH  rs2 operand
flush  input  1  abort the current operation (branch/jump redirect)
stall_EX  output  1  hold the EX stage
busy  output  1  state != IDLE
done  output  1  one-cycle pulse; result valid this cycle
result  output  WIDTH  selected product/quotient word; held until the next done

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, accumulator/product registers=0.
  - Outputs: result=0, done=0, busy=0, stall_EX=0.
- Supported op: aluop in {0101,0110,0111}, plus {1110,1111} when MULDIV_DIV_EN is defined. Any other aluop with start=1 is ignored: no state change, stall_EX=0.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN: on start & supported op & ~flush. Operands and op are latched, counter=WIDTH-1.
  - RUN: one shift-add iteration per cycle. The counter decrements. At counter==0 the next state is DONE, so RUN lasts exactly WIDTH cycles.
  - DONE: done=1, result is driven from the final registers, then unconditionally IDLE.
- Latency: start sampled at edge N; done high in the cycle after edge N+WIDTH, i.e. WIDTH+1 cycles of stall.
- stall_EX is combinational: (IDLE & start & supported & ~flush) | RUN. It is 0 in DONE so the instruction advances with the result.
- Arithmetic:
  - Unsigned 2*WIDTH-bit product via shift-add.
  - mul: low WIDTH bits. mulhu: high WIDTH bits.
  - mulh: signed x signed. Operand magnitudes are used and the 2*WIDTH product is two's-complement negated if op_a[MSB]^op_b[MSB]; result is the high word.
  - Most-negative operand: magnitude 2^(WIDTH-1) fits unsigned, so the result is exact.
- flush:
  - In RUN: next state IDLE, no done, result unchanged.
  - In IDLE with start: start is ignored.
  - In DONE: ignored, done still pulses.
- start while RUN/DONE: ignored. A new op is accepted only from IDLE, earliest the cycle after DONE.
- Async reset mid-RUN: immediate return to IDLE with all outputs at reset values.
- result register updates only on entry to DONE.

Optional Feature:
MULDIV_DIV_EN
- Defined: adds divu (1110) and remu (1111) using restoring division over the same WIDTH-cycle RUN.
  - Divide by zero: quotient = all ones, remainder = op_a (RISC-V semantics), still full latency.
- Undefined: 1110/1111 are unsupported ops and the divider logic is absent.

Decomposition:
- Shared package core_pkg:
  - aluop constants (ALU_MUL=4'b0101, ALU_MULH=4'b0110, ALU_MULHU=4'b0111, ALU_DIVU=4'b1110, ALU_REMU=4'b1111).
  - muldiv_state_t enum {IDLE, RUN, DONE}.
  - Default WIDTH localparam.
- Sub-module muldiv_dp: the iterative shift-add/restoring datapath registers, controlled by load/step/sign signals from this FSM.

Test Plan:
- mul 7*6: start at edge 0 -> stall_EX=1 for 33 cycles, done pulse in cycle 33, result=0x0000002A, busy=0 next cycle.
- mulh 0xFFFFFFFE (-2) * 3 -> result=0xFFFFFFFF. mulh 0x80000000*0x80000000 -> result=0x40000000.
- mulhu 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE. mul same operands -> 0x00000001.
- flush asserted in RUN cycle 10 -> busy=0 next cycle, no done, result keeps prior value. New start accepted the following cycle and completes normally.
- rst_n low mid-RUN, start re-asserted, aluop=0011 (add) -> immediate IDLE with outputs 0. start with aluop=0011 -> stall_EX=0, no state change.
- MULDIV_DIV_EN: divu 100/7 -> 14; remu 100/7 -> 2; divu 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5. Without the macro, aluop 1110 -> ignored.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer.
// Divide opcodes are supported only when MULDIV_DIV_EN is defined.
package core_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  localparam logic [3:0] ALU_MUL   = 4'b0101;
  localparam logic [3:0] ALU_MULH  = 4'b0110;
  localparam logic [3:0] ALU_MULHU = 4'b0111;
  localparam logic [3:0] ALU_DIVU  = 4'b1110;
  localparam logic [3:0] ALU_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  // Opcodes this build of the sequencer will accept.
  function automatic logic muldiv_supported(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      ALU_MUL, ALU_MULH, ALU_MULHU: ok = 1'b1;
`ifdef MULDIV_DIV_EN
      ALU_DIVU, ALU_REMU:           ok = 1'b1;
`endif
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic muldiv_is_div(input logic [3:0] op);
    return (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Radix-2 iterative datapath: shift-add multiply and, with MULDIV_DIV_EN,
// restoring divide. res_nxt_c is the result word as it will be after this step.
module muldiv_dp
  import core_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_nxt_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    prod_q, prod_d, prod_ld, step_nxt, mul_nxt;
  logic [WIDTH-1:0] mcand_q, mcand_d, mcand_ld;
  logic [WIDTH-1:0] a_mag, b_mag, neg_hi;
  logic [WIDTH:0]   mul_sum;
  logic [3:0]       op_q, op_d;
  logic             neg_q, neg_d, neg_ld;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   div_hi;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [PW-1:0]    div_nxt;
`endif

  // Operand conditioning at load: mulh works on magnitudes and remembers the sign.
  always_comb begin
    a_mag    = (op == ALU_MULH && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag    = (op == ALU_MULH && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    neg_ld   = (op == ALU_MULH) && (a[WIDTH-1] ^ b[WIDTH-1]);
    prod_ld  = {WIDTH'(0), b_mag};
    mcand_ld = a_mag;
`ifdef MULDIV_DIV_EN
    if (muldiv_is_div(op)) begin
      prod_ld  = {WIDTH'(0), a};
      mcand_ld = b;
    end
`endif
  end

  // One iteration; the product/remainder pair lives in prod_q.
  always_comb begin
    mul_sum  = {1'b0, prod_q[PW-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    mul_nxt  = {mul_sum, prod_q[WIDTH-1:1]};
    step_nxt = mul_nxt;
`ifdef MULDIV_DIV_EN
    div_hi   = prod_q[PW-1:WIDTH-1];
    div_ge   = div_hi >= {1'b0, mcand_q};
    div_diff = div_hi[WIDTH-1:0] - mcand_q;
    div_nxt  = {(div_ge ? div_diff : div_hi[WIDTH-1:0]), prod_q[WIDTH-2:0], div_ge};
    if (muldiv_is_div(op_q)) begin
      step_nxt = div_nxt;
    end
`endif
  end

  // High word of the two's-complement negated product, without forming the low half.
  always_comb begin
    neg_hi = ~step_nxt[PW-1:WIDTH] + WIDTH'(step_nxt[WIDTH-1:0] == '0);
    case (op_q)
      ALU_MULH:  res_nxt_c = neg_q ? neg_hi : step_nxt[PW-1:WIDTH];
      ALU_MULHU: res_nxt_c = step_nxt[PW-1:WIDTH];
`ifdef MULDIV_DIV_EN
      ALU_REMU:  res_nxt_c = step_nxt[PW-1:WIDTH];
`endif
      default:   res_nxt_c = step_nxt[WIDTH-1:0];
    endcase
  end

  always_comb begin
    prod_d  = prod_q;
    mcand_d = mcand_q;
    op_d    = op_q;
    neg_d   = neg_q;
    if (load) begin
      prod_d  = prod_ld;
      mcand_d = mcand_ld;
      op_d    = op;
      neg_d   = neg_ld;
    end else if (step) begin
      prod_d  = step_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      mcand_q <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage multi-cycle mul/mulh/mulhu sequencer; stalls the pipe while running.
// Define MULDIV_DIV_EN to add divu/remu on the same datapath.
module muldiv_sequencer
  import core_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall_EX,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d, dp_res;
  logic             busy_q, done_q;
  logic             accept, load, step;

  muldiv_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .op        (aluop),
    .a         (op_a),
    .b         (op_b),
    .res_nxt_c (dp_res)
  );

  assign accept = start && muldiv_supported(aluop) && !flush;

  // Next state, datapath control and the combinational stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    stall_EX = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RUN;
          cnt_d    = CNT_W'(WIDTH - 1);
          load     = 1'b1;
          stall_EX = 1'b1;
        end
      end
      RUN: begin
        stall_EX = 1'b1;
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d  = DONE;
            result_d = dp_res;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
